// File: rtl/dut_responder_pkg.sv
// Shared definitions for the DUT responder and the testbench scoreboard:
// latency clamp, injection-off constant and the injection counter width.
package dut_responder_pkg;

    localparam int          CTR_W      = 32;
    localparam logic [15:0] INJECT_OFF = 16'd0;

    // Requested latencies of 0 run at 1; anything above the pipeline depth runs at full depth.
    function automatic int clamp_latency(input int req, input int max_lat);
        if (req < 1) begin
            return 1;
        end
        if (req > max_lat) begin
            return max_lat;
        end
        return req;
    endfunction

endpackage

// File: rtl/dut_responder_if.sv
// Conduit between the stimulus driver (master) and the DUT responder (slave).
// There is no valid/ready pair: operands are sampled on every rising clk_dut edge.
interface dut_responder_if
    import dut_responder_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int MAX_LATENCY = 8
);
    localparam int LAT_W = $clog2(MAX_LATENCY + 1);

    logic [WIDTH-1:0] i_dut_a;
    logic [WIDTH-1:0] i_dut_b;
    logic [WIDTH-1:0] o_dut_out;
    logic [LAT_W-1:0] i_latency;
    logic [15:0]      i_inject_period;
    logic [WIDTH-1:0] i_inject_mask;
    logic [CTR_W-1:0] o_inject_ctr;
    logic             o_settling;
    // Debug view of the latency register and the settle countdown.
    logic [LAT_W-1:0] dbg_lat_q;
    logic [LAT_W-1:0] dbg_settle_cnt;

    modport master (
        output i_dut_a, i_dut_b, i_latency, i_inject_period, i_inject_mask,
        input  o_dut_out, o_inject_ctr, o_settling, dbg_lat_q, dbg_settle_cnt
    );

    modport slave (
        input  i_dut_a, i_dut_b, i_latency, i_inject_period, i_inject_mask,
        output o_dut_out, o_inject_ctr, o_settling, dbg_lat_q, dbg_settle_cnt
    );

endinterface

// File: rtl/dut_responder_delay_line.sv
// Shift register with a selectable tap: q carries d delayed by exactly 'tap' clocks (1..DEPTH).
// DEPTH-1 shift stages plus the registered output give DEPTH registered stages in total.
module dut_delay_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_dut,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic [SEL_W-1:0] tap,
    input  logic             zero,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH-1];
    logic [WIDTH-1:0] tap_val;

    // Tap 1 bypasses the shift stages; tap k reads the stage holding d from k-1 clocks ago.
    always_comb begin
        tap_val = d;
        for (int k = 2; k <= DEPTH; k++) begin
            if (int'(tap) == k) begin
                tap_val = stage[k-2];
            end
        end
    end

    always_ff @(posedge clk_dut) begin
        if (reset) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                stage[k] <= '0;
            end
            q <= '0;
        end else begin
            stage[0] <= d;
            for (int k = 1; k < DEPTH - 1; k++) begin
                stage[k] <= stage[k-1];
            end
            q <= zero ? '0 : tap_val;
        end
    end

endmodule

// File: rtl/dut_responder.sv
// Stand-in DUT: returns (a + b) mod 2^WIDTH after a runtime-selectable latency,
// with periodic XOR-mask corruption and a flush window after every latency change.
module dut_responder
    import dut_responder_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int MAX_LATENCY     = 8,
    parameter int DEFAULT_LATENCY = 2
) (
    input  logic           clk_dut,
    input  logic           reset,
    dut_responder_if.slave bus
);

    localparam int LAT_W = $clog2(MAX_LATENCY + 1);

    logic [LAT_W-1:0] lat_q;
    logic [LAT_W-1:0] lat_req;
    logic             lat_change;
    logic [LAT_W-1:0] settle_cnt;
    logic [LAT_W-1:0] settle_next;
    logic             settle_after;
    logic [15:0]      samp_cnt;
    logic             inject_hit;
    logic             inject_fire;
    logic [CTR_W-1:0] inject_ctr;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] stage_in;

    always_comb begin
        sum        = bus.i_dut_a + bus.i_dut_b;
        lat_req    = LAT_W'(clamp_latency(int'(bus.i_latency), MAX_LATENCY));
        lat_change = (lat_req != lat_q);

        settle_next = '0;
        if (lat_change) begin
            settle_next = LAT_W'(MAX_LATENCY);
        end else if (settle_cnt != '0) begin
            settle_next = settle_cnt - 1'b1;
        end
        settle_after = (settle_next != '0);

        // A sample taken on an edge that leaves o_settling high is never corrupted nor counted.
        inject_hit  = (bus.i_inject_period != INJECT_OFF) &&
                      (samp_cnt == bus.i_inject_period - 16'd1);
        inject_fire = inject_hit && !settle_after;
        stage_in    = inject_fire ? (sum ^ bus.i_inject_mask) : sum;
    end

    always_ff @(posedge clk_dut) begin
        if (reset) begin
            lat_q      <= LAT_W'(DEFAULT_LATENCY);
            settle_cnt <= '0;
            samp_cnt   <= '0;
            inject_ctr <= '0;
        end else begin
            lat_q      <= lat_req;
            settle_cnt <= settle_next;

            // A period lowered below the current count restarts the count without injecting.
            if (bus.i_inject_period == INJECT_OFF) begin
                samp_cnt <= '0;
            end else if (samp_cnt >= bus.i_inject_period) begin
                samp_cnt <= '0;
            end else if (inject_hit) begin
                samp_cnt <= '0;
            end else begin
                samp_cnt <= samp_cnt + 16'd1;
            end

            if (inject_fire && (inject_ctr != '1)) begin
                inject_ctr <= inject_ctr + 1'b1;
            end
        end
    end

    dut_delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (MAX_LATENCY),
        .SEL_W (LAT_W)
    ) u_delay (
        .clk_dut (clk_dut),
        .reset   (reset),
        .d       (stage_in),
        .tap     (lat_q),
        .zero    (settle_after),
        .q       (bus.o_dut_out)
    );

    assign bus.o_inject_ctr   = inject_ctr;
    assign bus.o_settling     = (settle_cnt != '0);
    assign bus.dbg_lat_q      = lat_q;
    assign bus.dbg_settle_cnt = settle_cnt;

endmodule

// File: tb/tb_dut_responder.sv
// Bench for dut_responder: table vectors, hand-written latency/injection/reset
// sequences and randomized traffic, all scored against a queue-based reference model.
module tb_dut_responder;
    import dut_responder_pkg::*;

    localparam int WIDTH   = 16;
    localparam int MAX_LAT = 8;
    localparam int DEF_LAT = 2;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);

    // ---------------- clock / reset ----------------
    logic clk_dut = 1'b0;
    logic reset;
    always #5 clk_dut = ~clk_dut;

    dut_responder_if #(.WIDTH(WIDTH), .MAX_LATENCY(MAX_LAT)) bus ();

    dut_responder #(
        .WIDTH           (WIDTH),
        .MAX_LATENCY     (MAX_LAT),
        .DEFAULT_LATENCY (DEF_LAT)
    ) u_dut (
        .clk_dut (clk_dut),
        .reset   (reset),
        .bus     (bus)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    // exp_q holds every value that entered the pipeline, newest at the back.
    logic [WIDTH-1:0] exp_q[$];
    int               m_lat;
    int               m_settle;
    int               m_phase;
    longint unsigned  m_ctr;
    logic [WIDTH-1:0] m_out;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour for one rising edge, computed from the inputs present at that edge.
    task automatic model_edge();
        int               req;
        int               per;
        logic [WIDTH-1:0] s;
        bit               corrupt;
        if (reset) begin
            m_lat    = DEF_LAT;
            m_settle = 0;
            m_phase  = 0;
            m_ctr    = 0;
            m_out    = '0;
            exp_q.delete();
            for (int i = 0; i < MAX_LAT; i++) exp_q.push_back('0);
            return;
        end
        req = int'(bus.i_latency);
        if (req == 0) req = 1;
        else if (req > MAX_LAT) req = MAX_LAT;
        if (req != m_lat) begin
            m_lat    = req;
            m_settle = MAX_LAT;
        end else if (m_settle > 0) begin
            m_settle--;
        end
        s       = WIDTH'((int'(bus.i_dut_a) + int'(bus.i_dut_b)) % 65536);
        corrupt = 1'b0;
        per     = int'(bus.i_inject_period);
        if (per == 0) m_phase = 0;
        else if (m_phase >= per) m_phase = 0;
        else if (m_phase == per - 1) begin
            m_phase = 0;
            corrupt = (m_settle == 0);
        end else m_phase++;
        if (corrupt) begin
            s = s ^ bus.i_inject_mask;
            if (m_ctr < 64'hFFFF_FFFF) m_ctr++;
        end
        exp_q.push_back(s);
        void'(exp_q.pop_front());
        m_out = (m_settle > 0) ? '0 : exp_q[exp_q.size() - m_lat];
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic tick();
        @(posedge clk_dut);
        model_edge();
        @(negedge clk_dut);
        check("out", 64'(bus.o_dut_out), 64'(m_out));
        check("settling", 64'(bus.o_settling), 64'(m_settle > 0));
        check("inject_ctr", 64'(bus.o_inject_ctr), m_ctr);
        check("lat_q", 64'(bus.dbg_lat_q), 64'(m_lat));
    endtask

    // Change latency, measure the settle window, then measure the echo delay of a step.
    task automatic lat_step(input int lat_in, input int exp_lat);
        int               n;
        int               settle_len;
        logic [WIDTH-1:0] step_val;
        bus.i_dut_a     = '0;
        bus.i_dut_b     = '0;
        bus.i_latency   = LAT_W'(lat_in);
        settle_len      = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!bus.o_settling) break;
            settle_len++;
            check("settle_out_zero", 64'(bus.o_dut_out), 64'd0);
        end
        check($sformatf("settle_len_l%0d", lat_in), 64'(settle_len), 64'(MAX_LAT));
        step_val      = WIDTH'(16'h1100 + lat_in);
        bus.i_dut_a   = step_val;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.o_dut_out !== step_val && n < 20);
        check($sformatf("echo_lat_l%0d", lat_in), 64'(n), 64'(exp_lat));
        bus.i_dut_a = '0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        int n_corr;
        int n_clean;
        int n_zero;
        int n;

        vecs[0] = '{16'h0001, 16'h0002, 16'h0003};
        vecs[1] = '{16'hFFFF, 16'h0003, 16'h0002};
        vecs[2] = '{16'h8000, 16'h8000, 16'h0000};
        vecs[3] = '{16'h1234, 16'h4321, 16'h5555};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 16'hFFFE};
        vecs[5] = '{16'h7FFF, 16'h0001, 16'h8000};

        reset               = 1'b1;
        bus.i_dut_a         = '0;
        bus.i_dut_b         = '0;
        bus.i_latency       = LAT_W'(DEF_LAT);
        bus.i_inject_period = INJECT_OFF;
        bus.i_inject_mask   = '0;
        repeat (3) tick();
        check("reset_out", 64'(bus.o_dut_out), 64'd0);
        check("reset_lat", 64'(bus.dbg_lat_q), 64'(DEF_LAT));

        // Table vectors streamed back to back at the default latency of 2.
        reset = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                bus.i_dut_a = vecs[i].a;
                bus.i_dut_b = vecs[i].b;
            end else begin
                bus.i_dut_a = '0;
                bus.i_dut_b = '0;
            end
            tick();
            if (i == 0) begin
                check("release_zero", 64'(bus.o_dut_out), 64'd0);
                check("release_settling", 64'(bus.o_settling), 64'd0);
            end else begin
                check($sformatf("vec%0d", i - 1), 64'(bus.o_dut_out), 64'(vecs[i-1].sum));
            end
        end

        // Latency sweep including both clamp boundaries.
        lat_step(5, 5);
        lat_step(0, 1);
        lat_step(12, 8);
        lat_step(2, 2);

        // Periodic injection from a clean reset.
        bus.i_inject_period = 16'd4;
        bus.i_inject_mask   = 16'h8000;
        bus.i_dut_a         = 16'h0010;
        bus.i_dut_b         = 16'h0000;
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        n_corr  = 0;
        n_clean = 0;
        n_zero  = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.o_dut_out == 16'h8010) n_corr++;
            else if (bus.o_dut_out == 16'h0010) n_clean++;
            else if (bus.o_dut_out == 16'h0000) n_zero++;
        end
        check("inj_ctr_100", 64'(bus.o_inject_ctr), 64'd25);
        check("inj_corrupt_outs", 64'(n_corr), 64'd24);
        check("inj_clean_outs", 64'(n_clean), 64'd75);
        check("inj_zero_outs", 64'(n_zero), 64'd1);

        // Injection suppressed while settling.
        bus.i_inject_period = 16'd1;
        bus.i_inject_mask   = 16'h00FF;
        repeat (3) tick();
        c0 = int'(bus.o_inject_ctr);
        bus.i_latency = LAT_W'(3);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!bus.o_settling) break;
            n++;
            check("settle_no_count", 64'(bus.o_inject_ctr), 64'(c0));
        end
        check("settle_inj_len", 64'(n), 64'(MAX_LAT));
        check("resume_count", 64'(bus.o_inject_ctr), 64'(c0 + 1));
        repeat (3) tick();
        check("resume_count3", 64'(bus.o_inject_ctr), 64'(c0 + 4));
        check("resume_corrupt", 64'(bus.o_dut_out), 64'h00EF);

        // Reset mid-run at L=6 with seven injections recorded.
        bus.i_latency = LAT_W'(6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        while (bus.o_inject_ctr != 32'd7 && n < 40) begin
            tick();
            n++;
        end
        check("midrun_ctr7", 64'(bus.o_inject_ctr), 64'd7);
        check("midrun_lat6", 64'(bus.dbg_lat_q), 64'd6);
        reset = 1'b1;
        tick();
        check("midrun_rst_out", 64'(bus.o_dut_out), 64'd0);
        check("midrun_rst_ctr", 64'(bus.o_inject_ctr), 64'd0);
        check("midrun_rst_settling", 64'(bus.o_settling), 64'd0);
        check("midrun_rst_lat", 64'(bus.dbg_lat_q), 64'(DEF_LAT));

        // Period lowered below the running count: wrap without injecting.
        bus.i_latency       = LAT_W'(DEF_LAT);
        bus.i_inject_period = 16'd8;
        bus.i_inject_mask   = 16'h0001;
        tick();
        reset = 1'b0;
        repeat (6) tick();
        bus.i_inject_period = 16'd3;
        tick();
        check("shrink_no_inj", 64'(bus.o_inject_ctr), 64'd0);
        repeat (3) tick();
        check("shrink_next_inj", 64'(bus.o_inject_ctr), 64'd1);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 1500; t++) begin
            bus.i_dut_a = WIDTH'($urandom);
            bus.i_dut_b = WIDTH'($urandom);
            if ($urandom_range(0, 39) == 0) bus.i_latency = LAT_W'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0)
                bus.i_inject_period = ($urandom_range(0, 2) == 0) ? INJECT_OFF
                                                                  : 16'($urandom_range(1, 9));
            if ($urandom_range(0, 29) == 0)
                bus.i_inject_mask = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dut_responder.md
# dut_responder

Synthesisable stand-in for the device under test, sitting on the far end of the testbench's DUT conduit. It receives the driver's operand pair every cycle and returns their modular sum after a runtime-selectable latency. It can periodically corrupt results with a programmable XOR mask, giving the monitor, scoreboard and delay-measurement logic known errors and known latencies to detect. It replaces the fixed two-stage internal adder when the conduit is wired to real pins.

## Interface

Parameters:
- WIDTH, 16, operand and result width
- MAX_LATENCY, 8, deepest supported pipeline (≥2)
- DEFAULT_LATENCY, 2, latency loaded at reset (1..MAX_LATENCY)

Ports:
- clk_dut  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- i_dut_a  in  WIDTH  operand A, sampled every cycle
- i_dut_b  in  WIDTH  operand B, sampled every cycle
- o_dut_out  out  WIDTH  delayed, possibly corrupted, sum
- i_latency  in  $clog2(MAX_LATENCY+1)  requested latency L
- i_inject_period  in  16  inject one error every N samples; 0 = off
- i_inject_mask  in  WIDTH  XOR mask applied to corrupted samples
- o_inject_ctr  out  32  number of corrupted samples issued
- o_settling  out  1  high while the pipeline flushes after a latency change

## Operation

- Sum: `(i_dut_a + i_dut_b) mod 2^WIDTH`; carry discarded.
- Pipeline: MAX_LATENCY registered stages, stage[0] loaded with the sum each cycle, stage[k] <= stage[k-1]; o_dut_out is registered from stage[L-1].
- Latency register lat_q: reset to DEFAULT_LATENCY.
  - Each cycle i_latency is clamped: 0 becomes 1; a value above MAX_LATENCY becomes MAX_LATENCY.
  - When the clamped value differs from lat_q, lat_q takes the new value and the settling counter loads MAX_LATENCY.
- Settling:
  - While the counter is non-zero, o_settling=1 and o_dut_out is forced to 0.
  - The pipeline keeps shifting during settling.
  - The counter decrements to 0; a further change mid-settle reloads it.
- Injection:
  - The sample counter increments every cycle when i_inject_period≠0.
  - When it equals period-1, the sum entering stage[0] is XORed with i_inject_mask, the counter wraps to 0, and o_inject_ctr increments.
  - The counter is held at 0 when period=0.
  - If a write makes the counter ≥ period, the counter wraps to 0 on the next cycle with no injection.
  - o_inject_ctr saturates at 2^32-1.
  - Injection is suppressed, and not counted, while o_settling=1; the sample counter still advances.
  - A zero mask still counts as an injection.
- Reset: all stages, o_dut_out, the sample counter and o_inject_ctr clear to 0; o_settling=0; lat_q=DEFAULT_LATENCY.

## Timing

- Operands presented in cycle t appear on o_dut_out in cycle t+L, with L=lat_q.
- At DEFAULT_LATENCY=2 the timing matches the legacy internal adder exactly.
- A latency change sampled at edge e:
  - o_settling rises after e.
  - o_settling stays high for MAX_LATENCY cycles.
  - The first valid output at the new L follows in the next cycle.
- Reset mid-operation takes effect at the next edge; the first post-reset valid result appears L cycles after reset deasserts.
- Injection timing: the corrupted result appears at the output L cycles after the corrupted sample is taken.

## Structure

- Shared testbench package holds:
  - the latency clamp function
  - the `INJECT_OFF` (period 0) constant
  - the counter width constant (32), shared with the scoreboard
- One sub-module, `dut_delay_line`: a WIDTH×MAX_LATENCY shift register with a registered tap select. It is reusable by the monitor for operand alignment.
- The top of `dut_responder` holds the adder, injection counter, latency and settle control.

## Test plan

- Reset release, L=2, A=0x0001, B=0x0002 at t=0 → o_dut_out=0x0003 at t=2; 0 before; o_settling=0.
- Wrap: A=0xFFFF, B=0x0003 → 0x0002.
- Latency sweep: set i_latency=5 → o_settling high for 8 cycles with output 0; then a step input is echoed exactly 5 cycles later. i_latency=0 behaves as 1; i_latency=12 behaves as 8.
- Injection: period=4, mask=0x8000, A+B=0x0010 constant → every 4th output = 0x8010, others 0x0010; o_inject_ctr=25 after 100 samples.
- Injection during settling: period=1, change latency → no corruption and no count while o_settling=1; both resume afterwards.
- Reset mid-run with o_inject_ctr=7, L=6 → all outputs 0 next cycle, lat_q=2, counter 0.
